// File: rtl/axis_frame_collector_pkg.sv
// -----------------------------------------------------------------------------
// axis_frame_collector_pkg
// Shared definitions for the frame collector and its buffer slots:
//   - frame header field offsets/widths
//   - items-per-frame helper
//   - output FSM state encoding
// -----------------------------------------------------------------------------
package axis_frame_collector_pkg;

  // Header occupies the low HDR_W bits of every frame.
  localparam int CNT_LSB  = 0;   // item count field LSB
  localparam int CNT_W    = 8;   // item count field width
  localparam int FLAG_BIT = 8;   // 1 = sealed by flush/timeout, 0 = sealed full
  localparam int HDR_W    = 16;  // total header width

  // Number of items that fit behind the header.
  function automatic int calc_max_items(input int data_width, input int item_width);
    return (data_width - HDR_W) / item_width;
  endfunction

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_t;

endpackage

// File: rtl/axis_frame_slot.sv
// -----------------------------------------------------------------------------
// axis_frame_slot
// One half of the collector's ping-pong buffer. Holds the item payload, the
// item count, the flush flag and the pending bit, and presents the assembled
// frame (header + payload).
//
// Ports:
//   i_clk, i_rst_n   clock / asynchronous active-low reset
//   i_wr_en          write i_wr_data at slot o_count, count increments
//   i_wr_data        item payload
//   i_seal           mark the buffer pending (may coincide with i_wr_en)
//   i_seal_flag      flag value captured on seal
//   i_release        frame consumed: clear payload, count, flag and pending
//   o_frame          assembled frame
//   o_pending        buffer sealed and waiting for the output side
//   o_count          items currently held
// -----------------------------------------------------------------------------
module axis_frame_slot
  import axis_frame_collector_pkg::*;
#(
  parameter int DATA_WIDTH = 4064,
  parameter int ITEM_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ITEM_WIDTH-1:0] i_wr_data,
  input  logic                  i_seal,
  input  logic                  i_seal_flag,
  input  logic                  i_release,
  output logic [DATA_WIDTH-1:0] o_frame,
  output logic                  o_pending,
  output logic [CNT_W-1:0]      o_count
);

  localparam int PAYLOAD_W = DATA_WIDTH - HDR_W;
  localparam int IDX_W     = $clog2(PAYLOAD_W);

  logic [PAYLOAD_W-1:0] r_buf;
  logic [CNT_W-1:0]     r_count;
  logic                 r_flag;
  logic                 r_pending;
  logic [IDX_W-1:0]     w_wr_base;
  logic [HDR_W-1:0]     w_hdr;

  assign w_wr_base = IDX_W'(int'(r_count) * ITEM_WIDTH);

  // Payload is cleared on release so unused item slots of the next frame
  // read back as zero without any masking on the output path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_buf     <= '0;
      r_count   <= '0;
      r_flag    <= 1'b0;
      r_pending <= 1'b0;
    end else if (i_release) begin
      r_buf     <= '0;
      r_count   <= '0;
      r_flag    <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_buf[w_wr_base +: ITEM_WIDTH] <= i_wr_data;
        r_count                        <= r_count + 1'b1;
      end
      if (i_seal) begin
        r_pending <= 1'b1;
        r_flag    <= i_seal_flag;
      end
    end
  end

  always_comb begin
    w_hdr                     = '0;
    w_hdr[CNT_LSB +: CNT_W]   = r_count;
    w_hdr[FLAG_BIT]           = r_flag;
  end

  assign o_frame   = {r_buf, w_hdr};
  assign o_pending = r_pending;
  assign o_count   = r_count;

endmodule

// File: rtl/axis_frame_collector.sv
// -----------------------------------------------------------------------------
// axis_frame_collector
// Packs ITEM_WIDTH-bit trace items into DATA_WIDTH-bit frames with a 16-bit
// header and hands them to the C2H packer. Two axis_frame_slot buffers form a
// ping-pong pair so filling continues while a frame is being drained.
//
// Optional build macro: COLLECT_TIMEOUT_EN -- seals a partial frame after
// TIMEOUT_CYCLES idle cycles as if flush had been pulsed.
//
// Ports:
//   m_axis_c2h_aclk     clock
//   m_axis_c2h_aresetn  asynchronous active-low reset
//   item_valid/item_data/item_ready   item input handshake
//   flush               pulse: seal the partial frame (ignored when empty)
//   data_valid/data     frame presented to the packer (stable while valid)
//   data_next           packer idle indicator; 1->0 while presenting = consumed
//   fill_level          items in the buffer currently being filled
//   frames_sent         frames consumed, modulo 2^16
// -----------------------------------------------------------------------------
module axis_frame_collector
  import axis_frame_collector_pkg::*;
#(
  parameter int DATA_WIDTH     = 4064,
  parameter int ITEM_WIDTH     = 32,
  parameter int MAX_ITEMS      = calc_max_items(DATA_WIDTH, ITEM_WIDTH)
`ifdef COLLECT_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                  m_axis_c2h_aclk,
  input  logic                  m_axis_c2h_aresetn,
  input  logic                  item_valid,
  input  logic [ITEM_WIDTH-1:0] item_data,
  output logic                  item_ready,
  input  logic                  flush,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data,
  input  logic                  data_next,
  output logic [7:0]            fill_level,
  output logic [15:0]           frames_sent
);

  // Slot signals
  logic [DATA_WIDTH-1:0] w_frame   [2];
  logic                  w_pending [2];
  logic [CNT_W-1:0]      w_count   [2];

  // Fill side
  logic       r_wr_sel;
  logic       r_blocked;     // sealed buffer waiting for the other to drain
  logic [7:0] w_fill;
  logic       w_item_acc;
  logic       w_full_seal;
  logic       w_flush_seal;
  logic       w_seal;
  logic       w_seal_flag;
  logic       w_other_pending;
  logic       w_timeout;

  // Output side
  out_state_t            r_state;
  out_state_t            w_state_next;
  logic                  r_rd_sel;
  logic                  r_dn_prev;
  logic                  r_data_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [15:0]           r_frames_sent;
  logic                  w_load;
  logic                  w_release;
  logic                  w_oldest;
  logic                  w_any_pending;

  // ---------------------------------------------------------------------------
  // Buffer slots
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      axis_frame_slot #(
        .DATA_WIDTH (DATA_WIDTH),
        .ITEM_WIDTH (ITEM_WIDTH)
      ) u_slot (
        .i_clk       (m_axis_c2h_aclk),
        .i_rst_n     (m_axis_c2h_aresetn),
        .i_wr_en     (w_item_acc && (r_wr_sel == 1'(gi))),
        .i_wr_data   (item_data),
        .i_seal      (w_seal && (r_wr_sel == 1'(gi))),
        .i_seal_flag (w_seal_flag),
        .i_release   (w_release && (r_rd_sel == 1'(gi))),
        .o_frame     (w_frame[gi]),
        .o_pending   (w_pending[gi]),
        .o_count     (w_count[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Fill side
  // ---------------------------------------------------------------------------
  // The fill buffer's own count doubles as fill_level: it reads the sealed
  // count while blocked and drops to zero the moment wr_sel moves on.
  assign w_fill          = w_count[r_wr_sel];
  assign w_other_pending = w_pending[~r_wr_sel];
  assign w_item_acc      = item_valid && !r_blocked;
  assign w_full_seal     = w_item_acc && (w_fill == 8'(MAX_ITEMS - 1));
  assign w_flush_seal    = (flush || w_timeout) && !r_blocked && (w_item_acc || (w_fill != 8'd0));
  assign w_seal          = w_full_seal || w_flush_seal;
  assign w_seal_flag     = !w_full_seal;   // full wins over a coincident flush

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      r_wr_sel  <= 1'b0;
      r_blocked <= 1'b0;
    end else if (w_seal) begin
      if (!w_other_pending) r_wr_sel  <= ~r_wr_sel;
      else                  r_blocked <= 1'b1;
    end else if (r_blocked && !w_other_pending) begin
      r_wr_sel  <= ~r_wr_sel;
      r_blocked <= 1'b0;
    end
  end

`ifdef COLLECT_TIMEOUT_EN
  logic [15:0] r_idle_cnt;

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      r_idle_cnt <= '0;
    end else if (w_item_acc || w_seal || r_blocked || (w_fill == 8'd0)) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 16'd1;
    end
  end

  assign w_timeout = (r_idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  // A blocked fill buffer was always sealed after the other one, so the
  // non-fill buffer is the older whenever it is pending.
  assign w_any_pending = w_pending[0] || w_pending[1];
  assign w_oldest      = w_pending[~r_wr_sel] ? ~r_wr_sel : r_wr_sel;

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_pending && data_next) begin
          w_load       = 1'b1;
          w_state_next = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        // r_dn_prev is 1 on entry (data_next was sampled high to load)
        if (r_dn_prev && !data_next) begin
          w_release    = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      r_dn_prev     <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_data_valid  <= 1'b0;
      r_data        <= '0;
      r_frames_sent <= '0;
    end else begin
      r_dn_prev <= data_next;
      if (w_load) begin
        r_data       <= w_frame[w_oldest];
        r_rd_sel     <= w_oldest;
        r_data_valid <= 1'b1;
      end
      if (w_release) begin
        r_data_valid  <= 1'b0;
        r_frames_sent <= r_frames_sent + 16'd1;
      end
    end
  end

  assign item_ready  = !r_blocked;
  assign data_valid  = r_data_valid;
  assign data        = r_data;
  assign fill_level  = w_fill;
  assign frames_sent = r_frames_sent;

endmodule

// File: tb/tb_axis_frame_collector.sv
// -----------------------------------------------------------------------------
// tb_axis_frame_collector
// Directed stimulus with a frame scoreboard: expected frames are queued as the
// stimulus is issued; a monitor pops and compares each frame when data_valid
// rises. A simple packer model drives data_next.
// -----------------------------------------------------------------------------
module tb_axis_frame_collector;

  localparam int DW = 4064;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          item_valid;
  logic [IW-1:0] item_data;
  logic          item_ready;
  logic          flush;
  logic          data_valid;
  logic [DW-1:0] data;
  logic          data_next;
  logic [7:0]    fill_level;
  logic [15:0]   frames_sent;

  int n_total = 0;
  int n_bad   = 0;

  logic [DW-1:0] sb_q[$];

  logic pk_hold;    // packer keeps data_next low
  logic pk_nocons;  // packer keeps data_next high, never consumes

  always #5 clk = ~clk;

  axis_frame_collector #(
    .DATA_WIDTH (DW),
    .ITEM_WIDTH (IW)
`ifdef COLLECT_TIMEOUT_EN
    , .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .m_axis_c2h_aclk    (clk),
    .m_axis_c2h_aresetn (rst_n),
    .item_valid         (item_valid),
    .item_data          (item_data),
    .item_ready         (item_ready),
    .flush              (flush),
    .data_valid         (data_valid),
    .data               (data),
    .data_next          (data_next),
    .fill_level         (fill_level),
    .frames_sent        (frames_sent)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  function automatic logic [DW-1:0] mk_frame(input logic [31:0] base, input int cnt,
                                             input logic [15:0] hdr);
    logic [DW-1:0] f;
    f = '0;
    f[15:0] = hdr;
    for (int k = 0; k < cnt; k++) f[16 + k*IW +: IW] = base + 32'(k);
    return f;
  endfunction

  // Called just after a negedge; returns just after the negedge that follows
  // the accepting posedge.
  task automatic send_item(input logic [31:0] d);
    int guard;
    guard = 0;
    item_valid = 1'b1;
    item_data  = d;
    while (!item_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 3000) check("item_ready_timeout", 64'(item_ready), 64'd1);
    @(negedge clk);
    item_valid = 1'b0;
  endtask

  task automatic send_item_flush(input logic [31:0] d);
    item_valid = 1'b1;
    item_data  = d;
    flush      = 1'b1;
    @(negedge clk);
    item_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_frames(input int n);
    int g;
    g = 0;
    while (frames_sent != 16'(n) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("frames_sent", 64'(frames_sent), 64'(n));
  endtask

  // Packer model
  initial begin
    int busy;
    busy = 0;
    data_next = 1'b0;
    forever begin
      @(negedge clk);
      if (pk_hold) data_next = 1'b0;
      else if (pk_nocons) data_next = 1'b1;
      else if (busy > 0) begin
        busy--;
        if (busy == 0) data_next = 1'b1;
      end else if (data_valid && data_next) begin
        data_next = 1'b0;
        busy = 3;
      end else data_next = 1'b1;
    end
  end

  // Scoreboard monitor
  initial begin
    logic          prev_v;
    logic [DW-1:0] exp_f;
    int            nfr;
    prev_v = 1'b0;
    nfr = 0;
    forever begin
      @(negedge clk);
      if (data_valid && !prev_v) begin
        n_total++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL frame_unexpected actual_hdr=%h required=none", data[15:0]);
        end else begin
          exp_f = sb_q.pop_front();
          if (data !== exp_f) begin
            n_bad++;
            $display("FAIL frame%0d actual_hdr=%h required_hdr=%h actual_lo=%h required_lo=%h diffbits=%0d",
                     nfr, data[15:0], exp_f[15:0], data[79:16], exp_f[79:16], $countones(data ^ exp_f));
          end else begin
            $display("ok   frame%0d hdr=%h", nfr, data[15:0]);
          end
        end
        nfr++;
      end
      prev_v = data_valid;
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_ready;
    int k_lat;
    rst_n      = 1'b0;
    item_valid = 1'b0;
    item_data  = '0;
    flush      = 1'b0;
    pk_hold    = 1'b1;
    pk_nocons  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data_valid", 64'(data_valid), 64'd0);
    check("rst_data_zero", 64'(|data), 64'd0);
    check("rst_item_ready", 64'(item_ready), 64'd1);
    check("rst_fill_level", 64'(fill_level), 64'd0);
    check("rst_frames_sent", 64'(frames_sent), 64'd0);

    rst_n   = 1'b1;
    pk_hold = 1'b0;
    @(negedge clk);

    // Full frame of 126 items 0x1..0x7E
    sb_q.push_back(mk_frame(32'h1, 126, 16'h007E));
    for (int k = 0; k < 126; k++) send_item(32'(k + 1));
    check("full_lat_edgeN", 64'(data_valid), 64'd0);
    check("full_fill_reset", 64'(fill_level), 64'd0);
    @(negedge clk);
    check("full_lat_edgeN1", 64'(data_valid), 64'd1);
    check("full_hdr", 64'(data[15:0]), 64'h007E);
    check("full_item0", 64'(data[47:16]), 64'h1);
    wait_frames(1);

    // 3 items then flush
    sb_q.push_back(mk_frame(32'hA000_0000, 3, 16'h0103));
    for (int k = 0; k < 3; k++) send_item(32'hA000_0000 + 32'(k));
    check("part_fill3", 64'(fill_level), 64'd3);
    do_flush();
    check("part_fill_reset", 64'(fill_level), 64'd0);
    wait_frames(2);

    // Item + flush same cycle at fill_level 125 (full wins) and at 10
    sb_q.push_back(mk_frame(32'h100, 126, 16'h007E));
    for (int k = 0; k < 125; k++) send_item(32'h100 + 32'(k));
    send_item_flush(32'h100 + 32'd125);
    sb_q.push_back(mk_frame(32'h500, 11, 16'h010B));
    for (int k = 0; k < 10; k++) send_item(32'h500 + 32'(k));
    send_item_flush(32'h500 + 32'd10);
    wait_frames(4);

    // Idle partial frame
    sb_q.push_back(mk_frame(32'h4000, 5, 16'h0105));
    for (int k = 0; k < 5; k++) send_item(32'h4000 + 32'(k));
`ifdef COLLECT_TIMEOUT_EN
    k_lat = 0;
    while (!data_valid && k_lat < 100) begin
      @(negedge clk);
      k_lat++;
    end
    check("timeout_latency", 64'(k_lat), 64'd17);
`else
    k_lat = 0;
    repeat (40) begin
      @(negedge clk);
      if (data_valid) k_lat++;
    end
    check("no_timeout_valid", 64'(k_lat), 64'd0);
    check("no_timeout_fill", 64'(fill_level), 64'd5);
    do_flush();
`endif
    wait_frames(5);

    // Packer stalled: both buffers fill, input backpressured
    pk_hold = 1'b1;
    sb_q.push_back(mk_frame(32'h1000, 126, 16'h007E));
    sb_q.push_back(mk_frame(32'h1000 + 32'd126, 126, 16'h007E));
    sb_q.push_back(mk_frame(32'h2000, 1, 16'h0101));
    for (int k = 0; k < 252; k++) send_item(32'h1000 + 32'(k));
    check("blocked_ready_253", 64'(item_ready), 64'd0);
    check("blocked_fill_max", 64'(fill_level), 64'd126);
    item_valid = 1'b1;
    item_data  = 32'h2000;
    n_ready = 0;
    repeat (48) begin
      @(negedge clk);
      if (item_ready) n_ready++;
    end
    check("blocked_ready_hold", 64'(n_ready), 64'd0);
    check("blocked_no_valid", 64'(data_valid), 64'd0);
    pk_hold = 1'b0;
    send_item(32'h2000);
    do_flush();
    wait_frames(8);

    // Reset while presenting with the second buffer pending
    pk_nocons = 1'b1;
    sb_q.push_back(mk_frame(32'h3000, 126, 16'h007E));
    for (int k = 0; k < 126; k++) send_item(32'h3000 + 32'(k));
    for (int k = 0; k < 5; k++) send_item(32'h3100 + 32'(k));
    do_flush();
    @(negedge clk);
    check("pre_rst_valid", 64'(data_valid), 64'd1);
    check("pre_rst_fill", 64'(fill_level), 64'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(data_valid), 64'd0);
    check("mid_rst_fill", 64'(fill_level), 64'd0);
    check("mid_rst_frames", 64'(frames_sent), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    pk_nocons = 1'b0;
    repeat (60) @(negedge clk);
    check("post_rst_valid", 64'(data_valid), 64'd0);
    check("post_rst_frames", 64'(frames_sent), 64'd0);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_frame_collector.md
Name: axis_frame_collector

Overview:
- Upstream neighbour of the AXIS C2H packer; same clock domain.
- Gathers ITEM_WIDTH-bit trace items from the core side into DATA_WIDTH-bit frames, each with a 16-bit header.
- Presents each frame on data/data_valid, handshaking with the packer's data_next.
- Ping-pong double buffer, so collection continues while the packer drains a frame.

Parameters:
- DATA_WIDTH, 4064: frame width; equals the packer's DATA_WIDTH.
- ITEM_WIDTH, 32: width of one input item.
- MAX_ITEMS, (DATA_WIDTH-16)/ITEM_WIDTH = 126: items per full frame.
- TIMEOUT_CYCLES, 1024: idle auto-flush threshold (optional feature only).

Ports:
- m_axis_c2h_aclk  in  1  sole clock.
- m_axis_c2h_aresetn  in  1  asynchronous active-low reset.
- item_valid  in  1  item offered.
- item_data  in  ITEM_WIDTH  item payload.
- item_ready  out  1  item accepted when item_valid && item_ready.
- flush  in  1  single-cycle pulse; seal the partial frame.
- data_valid  out  1  frame presented to the packer.
- data  out  DATA_WIDTH  frame; stable while data_valid = 1.
- data_next  in  1  packer idle/consume indicator.
- fill_level  out  8  items in the current fill buffer.
- frames_sent  out  16  frames handed off; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset (asynchronous):
  - Outputs: data_valid=0, data=0, item_ready=1, fill_level=0, frames_sent=0.
  - Both buffers empty; wr_sel=0; out state IDLE.
  - Reset mid-operation discards all partial and pending frames.
- Frame layout:
  - [7:0] item count (1..MAX_ITEMS).
  - [8] flush flag: 1 when the frame was sealed by flush/timeout, 0 when full.
  - [15:9] = 0.
  - Item k occupies [16+k*ITEM_WIDTH +: ITEM_WIDTH].
  - Bits above the last item are zero.
- Fill side:
  - Each accepted item is written at slot fill_level; fill_level increments.
  - Accepting item number MAX_ITEMS seals the buffer: pending=1, flag 0.
  - flush with fill_level>0 seals with flag 1. flush with fill_level=0 is ignored.
  - Item accepted and flush in the same cycle: the item is included, then the buffer is sealed.
  - If the item fills the frame in that same cycle, the flag is 0 (full wins).
  - On seal: if the other buffer is not pending, wr_sel toggles in the same edge and fill_level resets to 0.
  - Otherwise the sealed buffer is held; item_ready=0 until the other buffer is released. Then the swap happens, fill_level=0 and item_ready=1 on the next cycle.
- Out FSM:
  - IDLE: if a pending buffer exists and data_next=1 is sampled, load data from the oldest pending buffer, set data_valid=1, go to PRESENT.
  - PRESENT: hold data/data_valid. Acceptance is a sampled 1->0 transition of data_next. On acceptance: data_valid=0, release the buffer (pending=0), frames_sent+1, go to IDLE.
  - data_valid is never asserted while data_next=0 is sampled in IDLE. This guarantees the packer is in its idle state or one cycle before it.
- Latency:
  - Seal at edge N with output idle and data_next=1: data_valid high after edge N+1.
  - Buffers sealed in the same or adjacent cycles are presented in seal order.
- Widths: fill_level 8-bit, never exceeds MAX_ITEMS. frames_sent uses modulo-2^16 arithmetic.

Optional Feature:
- Macro: COLLECT_TIMEOUT_EN.
- Defined:
  - A 16-bit idle counter increments each cycle when fill_level>0 and no item is accepted; it clears on accept or seal.
  - Reaching TIMEOUT_CYCLES-1 seals the buffer exactly as flush does (flag 1).
  - Counter is held at 0 while the seal is blocked.
- Not defined: no counter; partial frames leave only on flush or full.

Decomposition:
- Shared package holds:
  - Header field offsets and widths (CNT_LSB=0, CNT_W=8, FLAG_BIT=8, HDR_W=16).
  - The MAX_ITEMS expression.
  - Out FSM state encoding (IDLE=0, PRESENT=1).
- One natural sub-module, axis_frame_slot, instantiated twice. It holds one DATA_WIDTH buffer, its item count, flag and pending bit, and provides write/seal/release controls.

Test Plan:
- 126 back-to-back items 0x1..0x7E, data_next=1 -> one frame; header 16'h007E; item0=0x1 at [47:16]; data_valid high 1 cycle after the 126th accept.
- 3 items then flush pulse -> header 16'h0103; bits above [111:16] zero; frames_sent=1 after data_next falls.
- data_next held 0 for 300 cycles while 252 items offered -> both buffers pending; item_ready=0 at the 253rd; after release, frames emitted in order with no loss.
- Item accept and flush in same cycle at fill_level=125 -> frame count 126, flag 0; at fill_level=10 -> count 11, flag 1.
- Assert reset while in PRESENT with the second buffer pending -> data_valid=0, fill_level=0, frames_sent=0 immediately; no frame emitted after reset release.
- COLLECT_TIMEOUT_EN, TIMEOUT_CYCLES=16: 5 items then idle -> frame header 16'h0105 presented after the 16th idle cycle plus 1.
